// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, register/field widths, the nop word and the
// writer FSM states.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [10:0] lc3b_offset11;
    typedef logic [8:0]  lc3b_offset9;
    typedef logic [5:0]  lc3b_offset6;
    typedef logic [4:0]  lc3b_imm5;
    typedef logic [3:0]  lc3b_imm4;
    typedef logic [7:0]  lc3b_trapvect8;

    // BR with nzp = 000 never branches.
    localparam lc3b_word lc3b_nop = 16'h0000;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } lc3b_writer_state;

endpackage

// File: rtl/lc3b_instr_encode.sv
// Purely combinational LC-3b field-to-word encoder (inverse of the IR decode).
module lc3b_instr_encode
    import lc3b_types::*;
(
    input  lc3b_opcode    opcode,
    input  lc3b_reg       dest,
    input  lc3b_reg       src1,
    input  lc3b_reg       src2,
    input  lc3b_offset11  offset11,
    input  lc3b_offset9   offset9,
    input  lc3b_offset6   offset6,
    input  lc3b_trapvect8 trapvect8,
    input  lc3b_imm5      imm5,
    input  lc3b_imm4      imm4,
    input  logic          mode4,
    input  logic          mode5,
    input  logic          mode11,
    output lc3b_word      word
);

    always_comb begin
        word = lc3b_nop;
        case (opcode)
            op_add, op_and: word = {opcode, dest, src1, mode5, (mode5 ? imm5 : {2'b00, src2})};
            op_not:         word = {opcode, dest, src1, 6'b111111};
            op_br, op_lea:  word = {opcode, dest, offset9};
            op_jmp:         word = {opcode, 3'b000, src1, 6'b000000};
            op_jsr:         word = mode11 ? {opcode, 1'b1, offset11}
                                          : {opcode, 1'b0, 2'b00, src1, 6'b000000};
            op_ldb, op_ldi, op_ldr,
            op_stb, op_sti, op_str: word = {opcode, dest, src1, offset6};
            op_shf:         word = {opcode, dest, src1, mode5, mode4, imm4};
            op_trap:        word = {opcode, 4'b0000, trapvect8};
            op_rti:         word = 16'h8000;
            default:        word = lc3b_nop;
        endcase
    end

endmodule

// File: rtl/lc3b_instr_writer.sv
// Encodes instruction field bundles and writes the words to sequential even
// addresses using the LC-3b memory handshake.
module lc3b_instr_writer
    import lc3b_types::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  lc3b_opcode    opcode,
    input  lc3b_reg       dest,
    input  lc3b_reg       src1,
    input  lc3b_reg       src2,
    input  lc3b_offset11  offset11,
    input  lc3b_offset9   offset9,
    input  lc3b_offset6   offset6,
    input  lc3b_trapvect8 trapvect8,
    input  lc3b_imm5      imm5,
    input  lc3b_imm4      imm4,
    input  logic          mode4,
    input  logic          mode5,
    input  logic          mode11,
    output logic [15:0]   mem_address,
    output logic [15:0]   mem_wdata,
    output logic          mem_write,
    output logic [1:0]    mem_byte_enable,
    input  logic          mem_resp,
    output logic [15:0]   word_count,
    output logic          full
);

    localparam logic [15:0] START_ADDR = BASE_ADDR & 16'hFFFE;
    localparam logic [15:0] WORD_LIMIT = 16'(MAX_WORDS);

    lc3b_writer_state state, next_state;
    lc3b_word         enc_word;
    logic             accept;
    logic             done;

    lc3b_instr_encode u_encode (
        .opcode    (opcode),
        .dest      (dest),
        .src1      (src1),
        .src2      (src2),
        .offset11  (offset11),
        .offset9   (offset9),
        .offset6   (offset6),
        .trapvect8 (trapvect8),
        .imm5      (imm5),
        .imm4      (imm4),
        .mode4     (mode4),
        .mode5     (mode5),
        .mode11    (mode11),
        .word      (enc_word)
    );

    assign full = (word_count == WORD_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // mem_write is decoded from state so an async reset drops it immediately.
    always_comb begin
        next_state      = state;
        in_ready        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        accept          = 1'b0;
        done            = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !full;
                if (in_valid && !full) begin
                    accept     = 1'b1;
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_write       = 1'b1;
                mem_byte_enable = 2'b11;
                if (mem_resp) begin
                    done       = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wdata   <= 16'h0000;
            mem_address <= START_ADDR;
            word_count  <= 16'h0000;
        end else begin
            if (accept) mem_wdata <= enc_word;
            if (done) begin
                mem_address <= mem_address + 16'd2;
                word_count  <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_instr_writer.sv
// Directed bench for lc3b_instr_writer: default, top-of-memory base and a
// two-word capacity instance share the field inputs.
module tb_lc3b_instr_writer;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    lc3b_opcode    opcode;
    lc3b_reg       dest, src1, src2;
    lc3b_offset11  offset11;
    lc3b_offset9   offset9;
    lc3b_offset6   offset6;
    lc3b_trapvect8 trapvect8;
    lc3b_imm5      imm5;
    lc3b_imm4      imm4;
    logic          mode4, mode5, mode11;

    logic [2:0]        in_valid, in_ready, mem_write, mem_resp, full;
    logic [2:0][15:0]  mem_address, mem_wdata, word_count;
    logic [2:0][1:0]   mem_byte_enable;

    int compared   = 0;
    int mismatched = 0;

    lc3b_instr_writer dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .offset11(offset11), .offset9(offset9), .offset6(offset6), .trapvect8(trapvect8),
        .imm5(imm5), .imm4(imm4), .mode4(mode4), .mode5(mode5), .mode11(mode11),
        .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_write(mem_write[0]),
        .mem_byte_enable(mem_byte_enable[0]), .mem_resp(mem_resp[0]),
        .word_count(word_count[0]), .full(full[0])
    );

    lc3b_instr_writer #(.BASE_ADDR(16'hFFFE)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .offset11(offset11), .offset9(offset9), .offset6(offset6), .trapvect8(trapvect8),
        .imm5(imm5), .imm4(imm4), .mode4(mode4), .mode5(mode5), .mode11(mode11),
        .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_write(mem_write[1]),
        .mem_byte_enable(mem_byte_enable[1]), .mem_resp(mem_resp[1]),
        .word_count(word_count[1]), .full(full[1])
    );

    lc3b_instr_writer #(.MAX_WORDS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .offset11(offset11), .offset9(offset9), .offset6(offset6), .trapvect8(trapvect8),
        .imm5(imm5), .imm4(imm4), .mode4(mode4), .mode5(mode5), .mode11(mode11),
        .mem_address(mem_address[2]), .mem_wdata(mem_wdata[2]), .mem_write(mem_write[2]),
        .mem_byte_enable(mem_byte_enable[2]), .mem_resp(mem_resp[2]),
        .word_count(word_count[2]), .full(full[2])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        opcode = op_br; dest = 3'd0; src1 = 3'd0; src2 = 3'd0;
        offset11 = 11'd0; offset9 = 9'd0; offset6 = 6'd0; trapvect8 = 8'd0;
        imm5 = 5'd0; imm4 = 4'd0; mode4 = 1'b0; mode5 = 1'b0; mode11 = 1'b0;
    endtask

    // One bundle with mem_resp returned in the first WRITE cycle (2 cycles/word).
    task automatic write_fast(input int i, input string tag, input logic [15:0] exp_word,
                              input logic [15:0] exp_addr, input logic [15:0] exp_count);
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        check({tag, "_write"}, 16'(mem_write[i]), 16'd1);
        check({tag, "_wdata"}, mem_wdata[i], exp_word);
        check({tag, "_addr"}, mem_address[i], exp_addr);
        mem_resp[i] = 1'b1;
        tick();
        mem_resp[i] = 1'b0;
        check({tag, "_write_low"}, 16'(mem_write[i]), 16'd0);
        check({tag, "_count"}, word_count[i], exp_count);
        check({tag, "_ready"}, 16'(in_ready[i]), 16'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 3'b000;
        mem_resp = 3'b000;
        clear_fields();
        #12;
        check("rst_write", 16'(mem_write[0]), 16'd0);
        check("rst_addr", mem_address[0], 16'h0000);
        check("rst_wdata", mem_wdata[0], 16'h0000);
        check("rst_be", 16'(mem_byte_enable[0]), 16'd0);
        check("rst_count", word_count[0], 16'd0);
        check("rst_full", 16'(full[0]), 16'd0);
        check("rst_ready", 16'(in_ready[0]), 16'd1);
        check("rst_addr_top", mem_address[1], 16'hFFFE);
        check("rst_full_max2", 16'(full[2]), 16'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // ADD R1,R2,#-3 with mem_resp in the third WRITE cycle
        opcode = op_add; dest = 3'd1; src1 = 3'd2; mode5 = 1'b1; imm5 = 5'b11101; src2 = 3'd6;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("add_write", 16'(mem_write[0]), 16'd1);
            check("add_wdata", mem_wdata[0], 16'h12BD);
            check("add_addr", mem_address[0], 16'h0000);
            check("add_be", 16'(mem_byte_enable[0]), 16'd3);
            check("add_ready_busy", 16'(in_ready[0]), 16'd0);
            if (c == 2) mem_resp[0] = 1'b1;
            tick();
        end
        mem_resp[0] = 1'b0;
        check("add_write_low", 16'(mem_write[0]), 16'd0);
        check("add_count", word_count[0], 16'd1);
        check("add_next_addr", mem_address[0], 16'h0002);

        clear_fields(); opcode = op_not; dest = 3'd3; src1 = 3'd4;
        write_fast(0, "not", 16'h973F, 16'h0002, 16'd2);
        clear_fields(); opcode = op_trap; trapvect8 = 8'h25;
        write_fast(0, "trap", 16'hF025, 16'h0004, 16'd3);
        clear_fields(); opcode = op_jsr; mode11 = 1'b1; offset11 = 11'h7FF; src1 = 3'd5;
        write_fast(0, "jsr", 16'h4FFF, 16'h0006, 16'd4);
        clear_fields(); opcode = op_jmp; src1 = 3'd7; dest = 3'd5;
        write_fast(0, "ret", 16'hC1C0, 16'h0008, 16'd5);
        clear_fields(); opcode = op_br; dest = 3'b010; offset9 = 9'h1FF;
        write_fast(0, "br", 16'h05FF, 16'h000A, 16'd6);
        clear_fields(); opcode = op_shf; dest = 3'd1; src1 = 3'd1; mode5 = 1'b1; mode4 = 1'b1; imm4 = 4'd3;
        write_fast(0, "shf", 16'hD273, 16'h000C, 16'd7);

        // mem_resp while idle must not move anything
        mem_resp[0] = 1'b1;
        tick();
        mem_resp[0] = 1'b0;
        check("idle_resp_count", word_count[0], 16'd7);
        check("idle_resp_addr", mem_address[0], 16'h000E);
        check("idle_resp_write", 16'(mem_write[0]), 16'd0);

        // address wraps past 0xFFFE
        clear_fields(); opcode = op_trap; trapvect8 = 8'h25;
        write_fast(1, "wrap0", 16'hF025, 16'hFFFE, 16'd1);
        write_fast(1, "wrap1", 16'hF025, 16'h0000, 16'd2);

        // capacity of two with a source holding in_valid high throughout
        clear_fields(); opcode = op_rti;
        in_valid[2] = 1'b1;
        mem_resp[2] = 1'b1;
        tick();
        check("cap_w0_write", 16'(mem_write[2]), 16'd1);
        check("cap_w0_wdata", mem_wdata[2], 16'h8000);
        tick();
        check("cap_w0_count", word_count[2], 16'd1);
        check("cap_w0_full", 16'(full[2]), 16'd0);
        check("cap_w0_ready", 16'(in_ready[2]), 16'd1);
        tick();
        check("cap_w1_write", 16'(mem_write[2]), 16'd1);
        check("cap_w1_addr", mem_address[2], 16'h0002);
        tick();
        check("cap_w1_count", word_count[2], 16'd2);
        check("cap_full", 16'(full[2]), 16'd1);
        check("cap_ready_low", 16'(in_ready[2]), 16'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("cap_no_third", 16'(mem_write[2]), 16'd0);
            check("cap_ready_stays_low", 16'(in_ready[2]), 16'd0);
        end
        check("cap_final_count", word_count[2], 16'd2);
        in_valid[2] = 1'b0;
        mem_resp[2] = 1'b0;

        // reset in the middle of a WRITE with mem_resp withheld
        clear_fields(); opcode = op_lea; dest = 3'd5; offset9 = 9'h0AB;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("midrst_write", 16'(mem_write[0]), 16'd1);
        check("midrst_wdata", mem_wdata[0], 16'hEAAB);
        check("midrst_addr", mem_address[0], 16'h000E);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_write_drop", 16'(mem_write[0]), 16'd0);
        check("midrst_be_drop", 16'(mem_byte_enable[0]), 16'd0);
        check("midrst_addr_base", mem_address[0], 16'h0000);
        check("midrst_count", word_count[0], 16'd0);
        check("midrst_ready", 16'(in_ready[0]), 16'd1);
        check("midrst_full_cleared", 16'(full[2]), 16'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_write", 16'(mem_write[0]), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
